pattern_loader: RTL and testbench

- Consumes the 2-bit pattern code from the switch-driven pattern selector.
- On a start pulse, writes the chosen seed (glider, blinker, beacon or acorn) into the cell-board memory, one full row per write.
- Every non-pattern cell is written to 0, so one load fully re-initialises the board.
- Sits between the user-input/selector logic and the board RAM, ahead of the generation engine.

---
 rtl/pattern_loader_if.sv | 28 ++
 rtl/pattern_loader.sv | 154 +++++++++++++++
 tb/tb_pattern_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_loader_if.sv
// Handshake bundle between the pattern selector, the loader and the board RAM write port.
// The master modport is the loader's view; slave is the surrounding environment.
interface pattern_loader_if #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16
);
    localparam int unsigned RW = $clog2(ROWS);

    logic            start;
    logic [1:0]      sel;
    logic            wr_ready;
    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            busy;
    logic            done;
    logic [1:0]      pattern_id;

    modport master (
        input  start, sel, wr_ready,
        output wr_en, wr_row, wr_data, busy, done, pattern_id
    );

    modport slave (
        output start, sel, wr_ready,
        input  wr_en, wr_row, wr_data, busy, done, pattern_id
    );
endinterface

// File: rtl/pattern_loader.sv
// Writes a selected seed pattern (glider/blinker/beacon/acorn) into the board RAM,
// one full row per write, clearing every other cell on the way.
module pattern_loader #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16,
    parameter int unsigned R0   = 4,
    parameter int unsigned C0   = 4
) (
    input logic              clk,
    input logic              rst_n,
    pattern_loader_if.master ld
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      pid_q, pid_d;

    logic transfer;
    logic last_row;

    // Pattern window is 8 columns wide; bit k of pat is pattern column k.
    function automatic logic [COLS-1:0] rom_row(input logic [1:0] id, input logic [RW-1:0] row);
        logic [COLS-1:0] word;
        logic [7:0]      pat;
        logic [1:0]      r;
        int unsigned     ri;
        word = '0;
        pat  = '0;
        ri   = 32'(row);
        r    = 2'(ri - R0);
        if (ri >= R0 && ri < R0 + 4) begin
            case (id)
                2'b00: begin
                    case (r)
                        2'd0:    pat = 8'h02;
                        2'd1:    pat = 8'h04;
                        2'd2:    pat = 8'h07;
                        default: pat = 8'h00;
                    endcase
                end
                2'b01: begin
                    case (r)
                        2'd1:    pat = 8'h07;
                        default: pat = 8'h00;
                    endcase
                end
                2'b10: begin
                    case (r)
                        2'd0, 2'd1: pat = 8'h03;
                        default:    pat = 8'h0C;
                    endcase
                end
                default: begin
                    case (r)
                        2'd0:    pat = 8'h02;
                        2'd1:    pat = 8'h08;
                        2'd2:    pat = 8'h73;
                        default: pat = 8'h00;
                    endcase
                end
            endcase
        end
        word[C0 +: 8] = pat;
        return word;
    endfunction

    assign transfer = wr_en_q & ld.wr_ready;
    assign last_row = (row_q == LastRow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_en_q <= 1'b0;
            row_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pid_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            row_q   <= row_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pid_q   <= pid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ld.start) state_d = StWrite;
            StWrite: if (transfer && last_row) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values for the registered outputs; the counter never advances past LastRow.
    always_comb begin
        wr_en_d = wr_en_q;
        row_d   = row_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pid_d   = pid_q;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (ld.start) begin
                    pid_d   = ld.sel;
                    row_d   = '0;
                    data_d  = rom_row(ld.sel, '0);
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StWrite: begin
                if (transfer) begin
                    if (last_row) begin
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        row_d  = row_q + 1'b1;
                        data_d = rom_row(pid_q, row_q + 1'b1);
                    end
                end
            end
            StDone: begin
                busy_d = 1'b0;
            end
            default: begin
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ld.wr_en      = wr_en_q;
    assign ld.wr_row     = row_q;
    assign ld.wr_data    = data_q;
    assign ld.busy       = busy_q;
    assign ld.done       = done_q;
    assign ld.pattern_id = pid_q;
endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader: expected row writes are queued at start and
// popped as each write handshake completes.
module tb_pattern_loader;
    localparam int unsigned ROWS = 16;
    localparam int unsigned COLS = 16;

    typedef struct packed {
        logic [3:0]  row;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_done;
    exp_t sb_q[$];

    logic        stall_q;
    logic [3:0]  stall_row;
    logic [15:0] stall_data;

    pattern_loader_if #(.ROWS(ROWS), .COLS(COLS)) ifc ();

    pattern_loader #(
        .ROWS(ROWS),
        .COLS(COLS),
        .R0  (4),
        .C0  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ld   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Independent reference: board row contents per pattern with R0=4, C0=4.
    function automatic logic [15:0] model_row(input logic [1:0] s, input int r);
        logic [15:0] v;
        v = 16'h0000;
        case (s)
            2'b00: case (r) 4: v = 16'h0020; 5: v = 16'h0040; 6: v = 16'h0070; default: ; endcase
            2'b01: case (r) 5: v = 16'h0070; default: ; endcase
            2'b10: case (r) 4, 5: v = 16'h0030; 6, 7: v = 16'h00C0; default: ; endcase
            default: case (r) 4: v = 16'h0020; 5: v = 16'h0080; 6: v = 16'h0730; default: ; endcase
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && ifc.wr_en) begin
                check("stall_row", 32'(ifc.wr_row), 32'(stall_row));
                check("stall_data", 32'(ifc.wr_data), 32'(stall_data));
            end
            if (ifc.wr_en && ifc.wr_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 32'(ifc.wr_row), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_row", 32'(ifc.wr_row), 32'(e.row));
                    check("wr_data", 32'(ifc.wr_data), 32'(e.data));
                end
            end
            if (ifc.done) n_done++;
            stall_q    = ifc.wr_en && !ifc.wr_ready;
            stall_row  = ifc.wr_row;
            stall_data = ifc.wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [1:0] s);
        for (int r = 0; r < ROWS; r++) begin
            exp_t e;
            e.row  = 4'(r);
            e.data = model_row(s, r);
            sb_q.push_back(e);
        end
    endtask

    // Starts a load in the current (idle) cycle and runs it to completion.
    // inject re-pulses start and moves sel to beacon mid-load; those must be ignored.
    task automatic do_load(input logic [1:0] s, input bit toggle, input int exp_cyc,
                           input bit inject);
        int cyc;
        int done_before;
        done_before = n_done;
        push_load(s);
        ifc.sel   = s;
        ifc.start = 1'b1;
        ifc.wr_ready = 1'b1;
        step();
        ifc.start = 1'b0;
        check("first_wr_en", 32'(ifc.wr_en), 32'd1);
        check("first_row", 32'(ifc.wr_row), 32'd0);
        check("busy_on", 32'(ifc.busy), 32'd1);
        cyc = 1;
        while (!ifc.done && cyc < 200) begin
            ifc.wr_ready = toggle ? cyc[0] : 1'b1;
            if (inject && cyc == 5) begin
                ifc.start = 1'b1;
                ifc.sel   = 2'b10;
            end else begin
                ifc.start = 1'b0;
            end
            step();
            cyc++;
        end
        ifc.start = 1'b0;
        check("done_cycle", 32'(cyc), 32'(exp_cyc));
        check("busy_in_done", 32'(ifc.busy), 32'd1);
        check("pattern_id", 32'(ifc.pattern_id), 32'(s));
        step();
        check("done_pulse_once", 32'(ifc.done), 32'd0);
        check("busy_off", 32'(ifc.busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(n_done - done_before), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, 32'(ifc.wr_en), 32'd0);
        check({tag, "_wr_row"}, 32'(ifc.wr_row), 32'd0);
        check({tag, "_wr_data"}, 32'(ifc.wr_data), 32'd0);
        check({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        check({tag, "_done"}, 32'(ifc.done), 32'd0);
        check({tag, "_pid"}, 32'(ifc.pattern_id), 32'd0);
    endtask

    initial begin
        int guard;
        n_checks = 0;
        n_pass   = 0;
        n_done   = 0;
        stall_q  = 1'b0;
        rst_n    = 1'b0;
        ifc.start    = 1'b0;
        ifc.sel      = 2'b00;
        ifc.wr_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_reset_values("reset");

        // Glider, full-speed; done 17 cycles after the start edge.
        do_load(2'b00, 1'b0, 17, 1'b0);
        // Acorn with alternating backpressure.
        do_load(2'b11, 1'b1, 32, 1'b0);
        // Glider with mid-load start/sel changes, then beacon back-to-back.
        do_load(2'b00, 1'b0, 17, 1'b1);
        do_load(2'b10, 1'b0, 17, 1'b0);
        // Back-to-back blinker then glider.
        do_load(2'b01, 1'b0, 17, 1'b0);
        do_load(2'b00, 1'b0, 17, 1'b0);

        // Reset while stalled on row 7.
        push_load(2'b11);
        ifc.sel      = 2'b11;
        ifc.start    = 1'b1;
        ifc.wr_ready = 1'b1;
        step();
        ifc.start = 1'b0;
        guard = 0;
        while (ifc.wr_row != 4'd7 && guard < 50) begin
            step();
            guard++;
        end
        check("reached_row7", 32'(ifc.wr_row), 32'd7);
        ifc.wr_ready = 1'b0;
        step();
        check("stalled_row7", 32'(ifc.wr_row), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wr_en", 32'(ifc.wr_en), 32'd0);
        check("async_busy", 32'(ifc.busy), 32'd0);
        sb_q.delete();
        ifc.wr_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_reset_values("post_reset");
        do_load(2'b01, 1'b0, 17, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
